// File: rtl/adc_frame_align_ctrl.sv
// rtl/adc_frame_align_ctrl.sv - LVDS deserializer frame alignment sequencer (bitslip/lock/re-align)
module adc_frame_align_ctrl #(
   parameter logic [7:0] FRAME_PATTERN = 8'hF0,
   parameter int         SETTLE_CYCLES = 16,
   parameter int         MATCH_CYCLES  = 64,
   parameter int         MAX_SLIPS     = 8,
   parameter int         LOSS_CYCLES   = 4
) (
   input  logic                         divclk,
   input  logic                         rst,
   input  logic                         align_req,
   input  logic [7:0]                   fclk_word,
   output logic                         bitslip,
   output logic                         ready,
   output logic                         align_fail,
   output logic [$clog2(MAX_SLIPS):0]   slip_cnt,
   output logic [7:0]                   relock_cnt
);

   localparam int STW = $clog2(SETTLE_CYCLES) + 1;
   localparam int MW  = $clog2(MATCH_CYCLES) + 1;
   localparam int SW  = $clog2(MAX_SLIPS) + 1;
   localparam int LW  = $clog2(LOSS_CYCLES) + 1;

   localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE_CYCLES - 1);
   localparam logic [MW-1:0]  MATCH_LAST  = MW'(MATCH_CYCLES - 1);
   localparam logic [SW-1:0]  SLIP_MAX    = SW'(MAX_SLIPS);
   localparam logic [LW-1:0]  LOSS_LAST   = LW'(LOSS_CYCLES - 1);

   typedef enum logic [2:0] {
      S_SETTLE = 3'd0,
      S_CHECK  = 3'd1,
      S_SLIP   = 3'd2,
      S_LOCKED = 3'd3,
      S_FAIL   = 3'd4
   } state_t;

   state_t           state_q;
   logic [STW-1:0]   settle_q;
   logic [MW-1:0]    match_q;
   logic [SW-1:0]    slip_q;
   logic [LW-1:0]    loss_q;
   logic [7:0]       relock_q;
   logic             bitslip_q;
   logic             ready_q;
   logic             fail_q;

   logic             word_ok;
   assign word_ok = (fclk_word == FRAME_PATTERN);

   always_ff @(posedge divclk) begin
      if (rst) begin
         state_q   <= S_SETTLE;
         settle_q  <= '0;
         match_q   <= '0;
         slip_q    <= '0;
         loss_q    <= '0;
         relock_q  <= '0;
         bitslip_q <= 1'b0;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else if (align_req) begin
         // Overrides every in-flight decision, including a pending slip.
         state_q   <= S_SETTLE;
         settle_q  <= '0;
         match_q   <= '0;
         slip_q    <= '0;
         loss_q    <= '0;
         bitslip_q <= 1'b0;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         bitslip_q <= 1'b0;
         case (state_q)
            S_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_q <= '0;
                  state_q  <= S_CHECK;
               end else begin
                  settle_q <= settle_q + STW'(1);
               end
            end
            S_CHECK: begin
               if (word_ok) begin
                  if (match_q == MATCH_LAST) begin
                     match_q <= '0;
                     loss_q  <= '0;
                     ready_q <= 1'b1;
                     state_q <= S_LOCKED;
                  end else begin
                     match_q <= match_q + MW'(1);
                  end
               end else begin
                  match_q <= '0;
                  if (slip_q == SLIP_MAX) begin
                     fail_q  <= 1'b1;
                     state_q <= S_FAIL;
                  end else begin
                     state_q <= S_SLIP;
                  end
               end
            end
            S_SLIP: begin
               // Strobe is issued on the edge leaving SLIP so a reset or request here cancels it.
               bitslip_q <= 1'b1;
               slip_q    <= slip_q + SW'(1);
               state_q   <= S_SETTLE;
            end
            S_LOCKED: begin
               if (word_ok) begin
                  loss_q <= '0;
               end else if (loss_q == LOSS_LAST) begin
                  loss_q  <= '0;
                  match_q <= '0;
                  slip_q  <= '0;
                  ready_q <= 1'b0;
                  if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                  state_q <= S_SETTLE;
               end else begin
                  loss_q <= loss_q + LW'(1);
               end
            end
            S_FAIL: begin
               state_q <= S_FAIL;
            end
            default: begin
               state_q <= S_SETTLE;
            end
         endcase
      end
   end

   assign bitslip    = bitslip_q;
   assign ready      = ready_q;
   assign align_fail = fail_q;
   assign slip_cnt   = slip_q;
   assign relock_cnt = relock_q;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// tb/tb_adc_frame_align_ctrl.sv - self-checking bench for adc_frame_align_ctrl
module tb_adc_frame_align_ctrl;

   localparam logic [7:0] PAT    = 8'hF0;
   localparam int         SETTLE = 16;
   localparam int         MATCH  = 64;
   localparam int         MAXS   = 8;
   localparam int         LOSS   = 4;
   localparam int         SLIP_COST = SETTLE + 2;

   logic       divclk = 1'b0;
   logic       rst = 1'b1;
   logic       align_req = 1'b0;
   logic [7:0] fclk_word = PAT;
   logic       bitslip;
   logic       ready;
   logic       align_fail;
   logic [3:0] slip_cnt;
   logic [7:0] relock_cnt;

   int n_pass = 0;
   int n_total = 0;
   int edge_n = 0;
   int abs_edge = 0;
   int last_bs = -1000;
   int bs_count = 0;
   int exp_relock = 0;
   int drop_at;
   int k;
   int n;
   logic       prev_bs = 1'b0;
   logic [7:0] cur_word = PAT;

   always #5 divclk = ~divclk;

   adc_frame_align_ctrl dut (
      .divclk     (divclk),
      .rst        (rst),
      .align_req  (align_req),
      .fclk_word  (fclk_word),
      .bitslip    (bitslip),
      .ready      (ready),
      .align_fail (align_fail),
      .slip_cnt   (slip_cnt),
      .relock_cnt (relock_cnt)
   );

   function automatic logic [7:0] rotr(input logic [7:0] w, input int r);
      logic [7:0] v = w;
      for (int i = 0; i < r; i++) v = {v[0], v[7:1]};
      return v;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] w, input int r);
      logic [7:0] v = w;
      for (int i = 0; i < r; i++) v = {v[6:0], v[7]};
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // One divclk edge; the ISERDES model rotates the word right by one bit per strobe.
   task automatic step();
      @(posedge divclk);
      #1;
      edge_n++;
      abs_edge++;
      if (bitslip === 1'b1) begin
         chk("bs_not_back_to_back", prev_bs, 0);
         chk("bs_spacing_ge_17", (abs_edge - last_bs) >= (SETTLE + 1), 1);
         last_bs  = abs_edge;
         bs_count++;
         cur_word  = rotr(cur_word, 1);
         fclk_word = cur_word;
      end
      prev_bs = bitslip;
   endtask

   task automatic wait_ready(input string tag, input int exp_edge);
      int lim = exp_edge + 200;
      while (ready !== 1'b1 && edge_n < lim) step();
      chk(tag, edge_n, exp_edge);
   endtask

   task automatic start_pass(input logic [7:0] word);
      cur_word  = word;
      fclk_word = word;
      align_req = 1'b1;
      step();
      align_req = 1'b0;
      edge_n    = 0;
      bs_count  = 0;
   endtask

   task automatic burst(input int len, input logic req_last, output int drop);
      logic [7:0] bad;
      drop = 0;
      for (int i = 1; i <= len; i++) begin
         do bad = 8'($urandom_range(0, 255)); while (bad == PAT);
         fclk_word = bad;
         align_req = (i == len) ? req_last : 1'b0;
         step();
         align_req = 1'b0;
         if (ready !== 1'b1 && drop == 0) drop = i;
      end
      fclk_word = cur_word;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_bitslip", bitslip, 0);
      chk("rst_ready", ready, 0);
      chk("rst_align_fail", align_fail, 0);
      chk("rst_slip_cnt", slip_cnt, 0);
      chk("rst_relock_cnt", relock_cnt, 0);

      rst = 1'b0;
      edge_n = 0;
      bs_count = 0;
      wait_ready("ready_edge_clean", SETTLE + MATCH);
      chk("clean_slip_cnt", slip_cnt, 0);
      chk("clean_align_fail", align_fail, 0);
      chk("clean_bitslips", bs_count, 0);

      start_pass(8'h87);
      chk("req_clears_ready", ready, 0);
      wait_ready("ready_edge_3slips", 3 * SLIP_COST + SETTLE + MATCH);
      chk("slips3_slip_cnt", slip_cnt, 3);
      chk("slips3_bitslips", bs_count, 3);

      for (int t = 0; t < 3; t++) begin
         k = $urandom_range(0, 7);
         start_pass(rotl(PAT, k));
         wait_ready("ready_edge_rand", k * SLIP_COST + SETTLE + MATCH);
         chk("rand_slip_cnt", slip_cnt, k);
         chk("rand_bitslips", bs_count, k);
      end

      burst(LOSS - 1, 1'b0, drop_at);
      step();
      chk("loss3_no_drop", drop_at, 0);
      chk("loss3_ready_held", ready, 1);
      chk("loss3_relock", relock_cnt, exp_relock);

      burst(LOSS, 1'b0, drop_at);
      exp_relock++;
      chk("loss4_drop_edge", drop_at, LOSS);
      chk("loss4_relock", relock_cnt, exp_relock);
      edge_n = 0;
      wait_ready("loss4_relock_edge", SETTLE + MATCH);

      for (int t = 0; t < 4; t++) begin
         n = $urandom_range(1, 6);
         burst(n, 1'b0, drop_at);
         if (n >= LOSS) begin
            exp_relock++;
            chk("rand_loss_drop_edge", drop_at, LOSS);
            chk("rand_loss_relock", relock_cnt, exp_relock);
            edge_n = n - LOSS;
            wait_ready("rand_loss_relock_edge", SETTLE + MATCH);
         end else begin
            step();
            chk("rand_loss_no_drop", drop_at, 0);
            chk("rand_loss_relock_same", relock_cnt, exp_relock);
         end
      end

      burst(LOSS, 1'b1, drop_at);
      chk("req_loss_drop_edge", drop_at, LOSS);
      chk("req_loss_relock_same", relock_cnt, exp_relock);
      edge_n = 0;
      wait_ready("req_loss_relock_edge", SETTLE + MATCH);

      start_pass(rotl(PAT, 2));
      repeat (SETTLE + 1) step();
      align_req = 1'b1;
      step();
      align_req = 1'b0;
      chk("req_in_slip_bitslip", bitslip, 0);
      chk("req_in_slip_slip_cnt", slip_cnt, 0);
      chk("req_in_slip_bitslips", bs_count, 0);
      edge_n = 0;
      bs_count = 0;
      wait_ready("req_in_slip_ready_edge", 2 * SLIP_COST + SETTLE + MATCH);
      chk("req_in_slip_final_slips", slip_cnt, 2);

      start_pass(8'hAA);
      while (align_fail !== 1'b1 && edge_n < 400) step();
      chk("fail_edge", edge_n, MAXS * SLIP_COST + SETTLE + 1);
      chk("fail_ready", ready, 0);
      chk("fail_slip_cnt", slip_cnt, MAXS);
      chk("fail_bitslips", bs_count, MAXS);
      repeat (40) step();
      chk("fail_no_more_bitslips", bs_count, MAXS);
      chk("fail_held", align_fail, 1);
      chk("fail_slip_cnt_held", slip_cnt, MAXS);
      start_pass(PAT);
      chk("fail_req_clears_fail", align_fail, 0);
      chk("fail_req_clears_slip_cnt", slip_cnt, 0);
      wait_ready("fail_restart_ready_edge", SETTLE + MATCH);

      while (exp_relock < 5) begin
         burst(LOSS, 1'b0, drop_at);
         exp_relock++;
         edge_n = 0;
         wait_ready("fill_relock_edge", SETTLE + MATCH);
      end
      chk("relock_is_5", relock_cnt, 5);

      start_pass(rotl(PAT, 3));
      while (bs_count < 2 && edge_n < 200) step();
      chk("pre_rst_bitslips", bs_count, 2);
      repeat (5) step();
      rst = 1'b1;
      step();
      chk("midrst_bitslip", bitslip, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_align_fail", align_fail, 0);
      chk("midrst_slip_cnt", slip_cnt, 0);
      chk("midrst_relock_cnt", relock_cnt, 0);
      rst = 1'b0;
      edge_n = 0;
      bs_count = 0;
      wait_ready("midrst_ready_edge", 1 * SLIP_COST + SETTLE + MATCH);
      chk("midrst_slip_cnt_final", slip_cnt, 1);

      start_pass(rotl(PAT, 1));
      repeat (SETTLE + 1) step();
      rst = 1'b1;
      step();
      chk("rst_in_slip_bitslip", bitslip, 0);
      chk("rst_in_slip_slip_cnt", slip_cnt, 0);
      rst = 1'b0;
      edge_n = 0;
      bs_count = 0;
      wait_ready("rst_in_slip_ready_edge", 1 * SLIP_COST + SETTLE + MATCH);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
